abacus_window_sequencer: RTL
============================

ABACUS_WINDOW_SEQUENCER -- requirements
Module: abacus_window_sequencer

Interface
REQ-001 The block SHALL have parameter WIN_W, default 32, giving the window-length and elapsed-counter width.
REQ-002 The block SHALL have parameter WCNT_W, default 16, giving the completed-window counter width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a profiling run.
REQ-006 The block SHALL have port stop, input, 1 bit, a one-cycle request to end the run after the current window.
REQ-007 The block SHALL have port unit_sel, input, 2 bits; bit0 selects the instruction profiler and bit1 the cache profiler.
REQ-008 The block SHALL have port window_len, input, WIN_W bits, giving the cycles per window; 0 means free-run until stop.
REQ-009 The block SHALL have port auto_rearm, input, 1 bit; when set, a new window starts automatically after each snapshot.
REQ-010 The block SHALL have port clear_on_start, input, 1 bit; when set, a counter-clear pulse is issued before each window.
REQ-011 The block SHALL have port snap_ack, input, 1 bit, by which the capture logic acknowledges a snapshot.
REQ-012 The block SHALL have port instr_enable, output, 1 bit, the instruction-profiler enable.
REQ-013 The block SHALL have port cache_enable, output, 1 bit, the cache-profiler enable.
REQ-014 The block SHALL have port counter_clear, output, 1 bit, a one-cycle clear pulse to the profiler counters.
REQ-015 The block SHALL have port snap_valid, output, 1 bit, a snapshot request held until snap_ack.
REQ-016 The block SHALL have ports busy, done and cfg_err, outputs, 1 bit each, giving status.
REQ-017 The block SHALL have port elapsed, output, WIN_W bits, the cycle count of the current window.
REQ-018 The block SHALL have port window_count, output, WCNT_W bits, the number of completed windows in the current run.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, CLEAR, RUN and SNAP.
REQ-020 In IDLE, the block SHALL accept a start with unit_sel!=0 and latch unit_sel, window_len, auto_rearm and clear_on_start; these latched copies govern the whole run.
REQ-021 On an accepted start, the block SHALL clear done, window_count and elapsed, and go to CLEAR if clear_on_start=1, else to RUN.
REQ-022 In IDLE, a start with unit_sel==0 SHALL be rejected: state stays IDLE and cfg_err is set.
REQ-023 cfg_err SHALL be sticky until the next accepted start.
REQ-024 start SHALL be ignored in any state other than IDLE.
REQ-025 stop SHALL be ignored in IDLE; if start and stop are asserted together in IDLE, start SHALL be accepted and stop dropped.
REQ-026 CLEAR SHALL last exactly one cycle with counter_clear=1 and the enables low, then go to RUN.
REQ-027 In RUN, the block SHALL drive instr_enable=latched sel[0] and cache_enable=latched sel[1], and increment elapsed each cycle.
REQ-028 elapsed SHALL saturate at all-ones.
REQ-029 In RUN with latched window_len!=0, the block SHALL go to SNAP in the cycle where elapsed==window_len-1, so enables are high for exactly window_len cycles.
REQ-030 In RUN, stop SHALL set stop_pending and cause a transition to SNAP on the next edge; window end and stop in the same cycle SHALL produce a single SNAP.
REQ-031 In SNAP, both enables SHALL be low and snap_valid high; snap_valid SHALL stay high until a cycle with snap_ack=1, with no timeout.
REQ-032 A stop arriving while in SNAP SHALL set stop_pending.
REQ-033 On the snap_ack cycle, window_count SHALL increment, saturating at all-ones, and elapsed SHALL reset to 0.
REQ-034 After the snap_ack cycle, the next state SHALL be CLEAR or RUN (per the latched clear_on_start) if latched auto_rearm=1 and stop_pending=0.
REQ-035 Otherwise, the next state after snap_ack SHALL be IDLE, with done set and stop_pending cleared.
REQ-036 snap_ack outside SNAP SHALL be ignored.
REQ-037 busy SHALL be 1 in every state except IDLE.
REQ-038 counter_clear and snap_valid SHALL never be high in the same cycle.
REQ-039 The enables SHALL be registered and change only on state transitions.
REQ-040 Latency from start: with clear_on_start=1, counter_clear is high at edge+1 and the enables are high at edge+2; with clear_on_start=0, the enables are high at edge+1.

Reset
REQ-041 When rst=0 at a clock edge, state SHALL become IDLE.
REQ-042 Reset SHALL clear all outputs, elapsed, window_count, stop_pending and the latched configuration to 0.
REQ-043 A reset in any state, including mid-SNAP with snap_valid high, SHALL take effect at that edge with no snapshot issued.

Verification
REQ-044 The bench SHALL cover: unit_sel=01, window_len=4, auto_rearm=0, clear_on_start=1, start, snap_ack 2 cycles after snap_valid -> one counter_clear pulse, instr_enable high exactly 4 cycles, cache_enable 0, window_count=1, done=1, busy=0.
REQ-045 The bench SHALL cover: unit_sel=11, window_len=3, auto_rearm=1, immediate acks, stop during the third window -> 3 SNAPs total, window_count=3, then IDLE with done=1.
REQ-046 The bench SHALL cover: window_len=0, start, stop after 100 cycles -> elapsed reaches 100 before SNAP, window_count=1.
REQ-047 The bench SHALL cover: start with unit_sel=00 -> cfg_err=1, busy=0, and no enables or pulses; a subsequent valid start clears cfg_err.
REQ-048 The bench SHALL cover: window_len=1 with stop asserted on the only RUN cycle -> exactly one SNAP, window_count=1, done=1.
REQ-049 The bench SHALL cover: rst=0 while snap_valid=1 -> next cycle all outputs 0 and state IDLE; a later snap_ack has no effect.

Source files
------------

// File: rtl/abacus_window_sequencer.sv
// Profiling window sequencer: runs the selected profilers for fixed or
// free-running windows and hands each window to capture logic via snap_valid.
module abacus_window_sequencer #(
    parameter int WIN_W  = 32,
    parameter int WCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        unit_sel,
    input  logic [WIN_W-1:0]  window_len,
    input  logic              auto_rearm,
    input  logic              clear_on_start,
    input  logic              snap_ack,
    output logic              instr_enable,
    output logic              cache_enable,
    output logic              counter_clear,
    output logic              snap_valid,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [WIN_W-1:0]  elapsed,
    output logic [WCNT_W-1:0] window_count
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, SNAP} state_t;

    state_t state, state_n;

    logic [1:0]        sel_q, sel_n;
    logic [WIN_W-1:0]  len_q, len_n;
    logic              rearm_q, rearm_n;
    logic              cos_q, cos_n;
    logic              sp_q, sp_n;
    logic              done_n, err_n;
    logic [WIN_W-1:0]  el_n;
    logic [WCNT_W-1:0] wc_n;
    logic              win_end;

    assign win_end = (len_q != '0) && (elapsed == len_q - WIN_W'(1));

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        len_n   = len_q;
        rearm_n = rearm_q;
        cos_n   = cos_q;
        sp_n    = sp_q;
        done_n  = done;
        err_n   = cfg_err;
        el_n    = elapsed;
        wc_n    = window_count;
        unique case (state)
            IDLE: begin
                if (start && (unit_sel != 2'b00)) begin
                    sel_n   = unit_sel;
                    len_n   = window_len;
                    rearm_n = auto_rearm;
                    cos_n   = clear_on_start;
                    sp_n    = 1'b0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    el_n    = '0;
                    wc_n    = '0;
                    state_n = clear_on_start ? CLEAR : RUN;
                end else if (start) begin
                    err_n = 1'b1;
                end
            end
            CLEAR: begin
                if (stop) sp_n = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                if (elapsed != '1) el_n = elapsed + WIN_W'(1);
                if (stop) sp_n = 1'b1;
                if (stop || sp_q || win_end) state_n = SNAP;
            end
            SNAP: begin
                if (stop) sp_n = 1'b1;
                if (snap_ack) begin
                    if (window_count != '1) wc_n = window_count + WCNT_W'(1);
                    el_n = '0;
                    // A stop seen on the ack cycle still ends the run
                    if (rearm_q && !(sp_q || stop)) begin
                        state_n = cos_q ? CLEAR : RUN;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        sp_n    = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            sel_q         <= '0;
            len_q         <= '0;
            rearm_q       <= 1'b0;
            cos_q         <= 1'b0;
            sp_q          <= 1'b0;
            instr_enable  <= 1'b0;
            cache_enable  <= 1'b0;
            counter_clear <= 1'b0;
            snap_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
            elapsed       <= '0;
            window_count  <= '0;
        end else begin
            state         <= state_n;
            sel_q         <= sel_n;
            len_q         <= len_n;
            rearm_q       <= rearm_n;
            cos_q         <= cos_n;
            sp_q          <= sp_n;
            instr_enable  <= (state_n == RUN) && sel_n[0];
            cache_enable  <= (state_n == RUN) && sel_n[1];
            counter_clear <= (state_n == CLEAR);
            snap_valid    <= (state_n == SNAP);
            busy          <= (state_n != IDLE);
            done          <= done_n;
            cfg_err       <= err_n;
            elapsed       <= el_n;
            window_count  <= wc_n;
        end
    end

endmodule
